// File: rtl/akuma_anim_ctrl.sv
// Purpose: animation/motion state machine for the Akuma sprite (pose, position, hitbox).
// Latency: one vga_clk; a decision taken on a frame_tick cycle shows on outputs next cycle.
// Backpressure: none; everything holds between frame_tick pulses.
module akuma_anim_ctrl #(
  parameter int X_INIT       = 120,
  parameter int GROUND_Y     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_V       = 12,
  parameter int PUNCH_FRAMES = 12
) (
  input  logic       vga_clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_punch,
  input  logic       hp_zero,
  output logic [2:0] sprite,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic       attack_active,
  output logic       airborne
);

  // State encoding equals the pose code, so the state register drives sprite directly.
  typedef enum logic [2:0] {
    ST_STAND    = 3'd0,
    ST_PUNCH    = 3'd1,
    ST_JUMP     = 3'd2,
    ST_CROUCH   = 3'd3,
    ST_WALK_L   = 3'd4,
    ST_WALK_R   = 3'd5,
    ST_DEAD     = 3'd6,
    ST_JUMP_ATK = 3'd7
  } state_t;

  localparam logic signed [11:0] XMIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
  localparam logic signed [11:0] STEP_S   = 12'(WALK_STEP);
  localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
  localparam logic signed [11:0] JUMP_S   = 12'(JUMP_V);
  // The launch tick already applies -JUMP_V, so vy leaves that tick one higher.
  localparam logic signed [7:0]  VY_AFTER_LAUNCH = 8'(1 - JUMP_V);
  localparam logic [3:0]         PUNCH_LAST      = 4'(PUNCH_FRAMES - 1);

  state_t            state;
  logic signed [7:0] vy;
  logic [3:0]        cnt;
  logic signed [1:0] dir;

  logic signed [1:0]  dir_sel;
  logic signed [11:0] y_ext;
  logic signed [11:0] y_sum;
  logic signed [11:0] y_launch;
  logic               land;
  logic [9:0]         x_step_l;
  logic [9:0]         x_step_r;
  logic [9:0]         x_air;
  logic [9:0]         x_launch;
  logic [3:0]         cnt_inc;
  state_t             grd_next;

  // Signed 12-bit arithmetic keeps X from wrapping below 0 or past the right edge.
  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < XMIN_S) return XMIN_S[9:0];
    if (v > XMAX_S) return XMAX_S[9:0];
    return v[9:0];
  endfunction

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic signed [1:0] d);
    logic signed [11:0] xs;
    xs = $signed({2'b00, x});
    case (d)
      2'sb11:  return clamp_x(xs - STEP_S);
      2'sb01:  return clamp_x(xs + STEP_S);
      default: return x;
    endcase
  endfunction

  // Grounded command priority, and the motion candidates used by the FSM below.
  always_comb begin
    grd_next = ST_STAND;
    if (key_punch)                  grd_next = ST_PUNCH;
    else if (key_up)                grd_next = ST_JUMP;
    else if (key_down)              grd_next = ST_CROUCH;
    else if (key_left && key_right) grd_next = ST_STAND;
    else if (key_left)              grd_next = ST_WALK_L;
    else if (key_right)             grd_next = ST_WALK_R;

    dir_sel = 2'sb00;
    if (key_left && !key_right)      dir_sel = 2'sb11;
    else if (key_right && !key_left) dir_sel = 2'sb01;

    y_ext    = $signed({2'b00, AkumaY});
    y_sum    = y_ext + $signed({{4{vy[7]}}, vy});
    y_launch = y_ext - JUMP_S;
    land     = (vy > 8'sd0) && (y_sum >= GROUND_S);
    x_step_l = step_x(AkumaX, 2'sb11);
    x_step_r = step_x(AkumaX, 2'sb01);
    x_air    = step_x(AkumaX, dir);
    x_launch = step_x(AkumaX, dir_sel);
    cnt_inc  = cnt + 4'd1;
  end

  assign sprite = state;

  // FSM, position, velocity and registered flags; updates only on frame_tick.
  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      state         <= ST_STAND;
      AkumaX        <= 10'(X_INIT);
      AkumaY        <= 10'(GROUND_Y);
      vy            <= '0;
      cnt           <= '0;
      dir           <= '0;
      attack_active <= 1'b0;
      airborne      <= 1'b0;
    end else if (frame_tick) begin
      attack_active <= 1'b0;
      airborne      <= 1'b0;
      if (hp_zero) begin
        state <= ST_DEAD;
        vy    <= '0;
        if (airborne) AkumaY <= 10'(GROUND_Y);
      end else begin
        case (state)
          ST_DEAD: ;
          ST_PUNCH: begin
            if (cnt == PUNCH_LAST) begin
              state <= ST_STAND;
            end else begin
              cnt           <= cnt_inc;
              attack_active <= (cnt_inc >= 4'd4) && (cnt_inc <= 4'd7);
            end
          end
          ST_JUMP, ST_JUMP_ATK: begin
            AkumaX <= x_air;
            if (land) begin
              AkumaY <= 10'(GROUND_Y);
              vy     <= '0;
              state  <= ST_STAND;
            end else begin
              AkumaY   <= y_sum[9:0];
              vy       <= vy + 8'sd1;
              airborne <= 1'b1;
              if (state == ST_JUMP_ATK || key_punch) begin
                state         <= ST_JUMP_ATK;
                attack_active <= 1'b1;
              end
            end
          end
          default: begin
            state <= grd_next;
            case (grd_next)
              ST_PUNCH:  cnt <= '0;
              ST_JUMP: begin
                airborne <= 1'b1;
                AkumaY   <= y_launch[9:0];
                AkumaX   <= x_launch;
                vy       <= VY_AFTER_LAUNCH;
                dir      <= dir_sel;
              end
              ST_WALK_L: AkumaX <= x_step_l;
              ST_WALK_R: AkumaX <= x_step_r;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_akuma_anim_ctrl.sv
// Purpose: randomized + directed bench for akuma_anim_ctrl against a behavioural model.
// Latency: samples outputs 1 time unit after each vga_clk rising edge.
// Backpressure: none; the bench drives frame_tick and keys directly.
module tb_akuma_anim_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_punch = 1'b0;
  logic       hp_zero = 1'b0;
  logic [2:0] sprite;
  logic [9:0] AkumaX, AkumaY;
  logic       attack_active, airborne;

  int checks = 0;
  int failures = 0;

  // Behavioural model: pose code, pixel position, velocity, jump direction, punch frame.
  int m_pose, m_x, m_y, m_vy, m_dir, m_cnt;

  akuma_anim_ctrl dut (
    .vga_clk(vga_clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_punch(key_punch), .hp_zero(hp_zero),
    .sprite(sprite), .AkumaX(AkumaX), .AkumaY(AkumaY),
    .attack_active(attack_active), .airborne(airborne)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampx(input int v);
    if (v < 0) return 0;
    if (v > 560) return 560;
    return v;
  endfunction

  function automatic bit m_air();
    return (m_pose == 2) || (m_pose == 7);
  endfunction

  function automatic bit m_attack();
    return (m_pose == 7) || (m_pose == 1 && m_cnt >= 4 && m_cnt <= 7);
  endfunction

  task automatic model_reset();
    m_pose = 0; m_x = 120; m_y = 300; m_vy = 0; m_dir = 0; m_cnt = 0;
  endtask

  // One airborne frame of ballistic motion; returns 1 on touchdown.
  task automatic model_fly(output bit landed);
    m_x = clampx(m_x + 2 * m_dir);
    landed = (m_vy > 0) && (m_y + m_vy >= 300);
    if (landed) m_y = 300;
    else begin
      m_y += m_vy;
      m_vy += 1;
    end
  endtask

  task automatic model_tick(input bit l, r, u, d, p, hp);
    bit landed;
    if (hp) begin
      if (m_air()) m_y = 300;
      m_pose = 6;
    end else if (m_pose == 6) begin
    end else if (m_pose == 1) begin
      if (m_cnt == 11) m_pose = 0;
      else m_cnt++;
    end else if (m_air()) begin
      model_fly(landed);
      if (landed) m_pose = 0;
      else if (p) m_pose = 7;
    end else begin
      if (p) begin m_pose = 1; m_cnt = 0; end
      else if (u) begin
        m_pose = 2;
        m_vy = -12;
        m_dir = (l && !r) ? -1 : (r && !l) ? 1 : 0;
        model_fly(landed);
      end
      else if (d) m_pose = 3;
      else if (l && r) m_pose = 0;
      else if (l) begin m_pose = 4; m_x = clampx(m_x - 2); end
      else if (r) begin m_pose = 5; m_x = clampx(m_x + 2); end
      else m_pose = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sprite"}, int'(sprite), m_pose);
    chk({tag, ".x"}, int'(AkumaX), m_x);
    chk({tag, ".y"}, int'(AkumaY), m_y);
    chk({tag, ".attack"}, int'(attack_active), int'(m_attack()));
    chk({tag, ".airborne"}, int'(airborne), int'(m_air()));
  endtask

  // Reset with frame_tick and random keys asserted, proving the tick is ignored.
  task automatic do_reset();
    @(negedge vga_clk);
    Reset_n = 1'b0; frame_tick = 1'b1;
    {key_left, key_right, key_up, key_down, key_punch, hp_zero} = 6'($urandom);
    @(posedge vga_clk); #1;
    model_reset();
    chk("rst.sprite", int'(sprite), 0);
    chk("rst.x", int'(AkumaX), 120);
    chk("rst.y", int'(AkumaY), 300);
    chk("rst.attack", int'(attack_active), 0);
    chk("rst.airborne", int'(airborne), 0);
    frame_tick = 1'b0; Reset_n = 1'b1;
    {key_left, key_right, key_up, key_down, key_punch, hp_zero} = '0;
  endtask

  task automatic tick(input bit l, r, u, d, p, hp);
    @(negedge vga_clk);
    {key_left, key_right, key_up, key_down, key_punch, hp_zero} = {l, r, u, d, p, hp};
    frame_tick = 1'b1;
    @(posedge vga_clk); #1;
    frame_tick = 1'b0;
    model_tick(l, r, u, d, p, hp);
    check_all("tick");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge vga_clk);
    #1;
    check_all("hold");
  endtask

  initial begin
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge vga_clk);
    do_reset();

    // Walk right five frames from X_INIT.
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0, 0);
    chk("walk_r.sprite", int'(sprite), 5);
    chk("walk_r.x", int'(AkumaX), 130);
    chk("walk_r.y", int'(AkumaY), 300);

    // Walk left down to X=2, then press into the left clamp.
    for (int i = 0; i < 64; i++) tick(1, 0, 0, 0, 0, 0);
    chk("walk_l.at2", int'(AkumaX), 2);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      chk("clamp_l.x", int'(AkumaX), 0);
    end
    idle(3);

    // Straight jump trajectory.
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    chk("jump1.y", int'(AkumaY), 288);
    chk("jump1.air", int'(airborne), 1);
    for (int t = 2; t <= 25; t++) begin
      tick(0, 0, 0, 0, 0, 0);
      if (t == 12) chk("jump.peak", int'(AkumaY), 222);
      if (t == 25) begin
        chk("jump.land_y", int'(AkumaY), 300);
        chk("jump.land_sprite", int'(sprite), 0);
        chk("jump.land_air", int'(airborne), 0);
      end
    end

    // Punch, then key_up held: keys ignored during punch, jump after STAND.
    do_reset();
    tick(0, 0, 0, 0, 1, 0);
    for (int t = 1; t <= 14; t++) begin
      if (t > 1) tick(0, 0, 1, 0, 0, 0);
      if (t <= 12) begin
        chk("punch.sprite", int'(sprite), 1);
        chk("punch.attack", int'(attack_active), int'(t - 1 >= 4 && t - 1 <= 7));
      end
      if (t == 13) chk("punch.end", int'(sprite), 0);
      if (t == 14) chk("punch.then_jump", int'(sprite), 2);
    end

    // Jump attack from tick 5 until landing.
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    for (int t = 2; t <= 25; t++) begin
      tick(0, 0, 0, 0, t == 5, 0);
      if (t >= 5 && t < 25) begin
        chk("jatk.sprite", int'(sprite), 7);
        chk("jatk.attack", int'(attack_active), 1);
      end
      if (t == 25) chk("jatk.land", int'(attack_active), 0);
    end

    // Death mid-jump is sticky and grounds the sprite.
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    for (int t = 2; t <= 8; t++) tick(0, 0, 0, 0, 0, t == 8);
    chk("dead.sprite", int'(sprite), 6);
    chk("dead.y", int'(AkumaY), 300);
    for (int i = 0; i < 100; i++)
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("dead.sticky", int'(sprite), 6);

    // Reset in the middle of a leftward jump, then both horizontal keys.
    do_reset();
    tick(1, 0, 1, 0, 0, 0);
    for (int t = 2; t <= 9; t++) tick(0, 0, 0, 0, 0, 0);
    do_reset();
    tick(1, 1, 0, 0, 0, 0);
    chk("lr.sprite", int'(sprite), 0);
    chk("lr.x", int'(AkumaX), 120);

    // Randomized play: held key patterns, idle gaps, rare death and reset.
    for (int seg = 0; seg < 300; seg++) begin
      bit [4:0] keys;
      int len;
      keys = 5'($urandom);
      if ($urandom_range(0, 3) != 0) keys[4] = 1'b0;
      if ($urandom_range(0, 2) != 0) keys[2] = 1'b0;
      len = $urandom_range(1, 20);
      if ($urandom_range(0, 40) == 0) do_reset();
      for (int i = 0; i < len; i++) begin
        tick(keys[0], keys[1], keys[2], keys[3], keys[4], $urandom_range(0, 400) == 0);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
